// File: rtl/pipe_pkg.sv
// Shared constants and sizing helpers for the pipe_buf slice.
package pipe_pkg;

  localparam int DEFAULT_XLEN  = 32;
  localparam int DEFAULT_DEPTH = 2;

  // Width needed to hold an occupancy value from 0 up to depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width; a single-entry buffer still needs a 1-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_buf_ram.sv
// Storage array for pipe_buf: one synchronous write port, one asynchronous read port.
// Contents are never cleared; the owner decides when a slot holds valid data.
module pipe_buf_ram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem [DEPTH];

  // Write the addressed slot on each enabled rising edge.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/pipe_buf.sv
// pipe_buf: valid/ready buffer between two pipeline stages with flush.
// Optional zero-latency pass-through when empty is enabled by defining PIPE_BUF_BYPASS_EN.
module pipe_buf
  import pipe_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  input  logic [XLEN-1:0]               in_data_i,
  output logic                          in_ready_o,
  output logic                          out_valid_o,
  output logic [XLEN-1:0]               out_data_o,
  input  logic                          out_ready_i,
  output logic [count_width(DEPTH)-1:0] count_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int CW = count_width(DEPTH);
  localparam int AW = ptr_width(DEPTH);
  localparam logic [AW-1:0] LAST_PTR   = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            bypass;
  logic            push;
  logic            pop;
  logic            ram_we;
  logic [XLEN-1:0] ram_rdata;

  // Pointers wrap explicitly so non power-of-two depths work.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // A flush empties the buffer anyway, so the producer is never held off by it.
  assign in_ready_o = !full || out_ready_i || flush_i;

`ifdef PIPE_BUF_BYPASS_EN
  assign bypass      = empty && out_ready_i;
  assign out_valid_o = empty ? (bypass && in_valid_i) : 1'b1;
  assign out_data_o  = (bypass && in_valid_i) ? in_data_i
                                              : (empty ? '0 : ram_rdata);
`else
  assign bypass      = 1'b0;
  assign out_valid_o = !empty;
  assign out_data_o  = empty ? '0 : ram_rdata;
`endif

  // A bypassed beat goes straight to the consumer and never touches storage.
  assign push   = in_valid_i && in_ready_o && !bypass;
  assign pop    = !empty && out_ready_i;
  assign ram_we = push && !flush_i && !rst_i;

  // Pointer and occupancy update; reset beats flush, flush beats push and pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  pipe_buf_ram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (wr_ptr),
    .wdata_i (in_data_i),
    .raddr_i (rd_ptr),
    .rdata_o (ram_rdata)
  );

  assign count_o = count;
  assign full_o  = full;
  assign empty_o = empty;

endmodule

// File: tb/tb_pipe_buf.sv
// Directed self-checking bench for pipe_buf (DEPTH=2 and DEPTH=3 instances).
module tb_pipe_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [1:0]  count;
  logic        full;
  logic        empty;

  logic        flush3;
  logic        in_valid3;
  logic [31:0] in_data3;
  logic        in_ready3;
  logic        out_valid3;
  logic [31:0] out_data3;
  logic        out_ready3;
  logic [1:0]  count3;
  logic        full3;
  logic        empty3;

  int checks = 0;
  int errors = 0;

  pipe_buf #(.XLEN(32), .DEPTH(2)) dut2 (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ready_i (out_ready),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

  pipe_buf #(.XLEN(32), .DEPTH(3)) dut3 (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush3),
    .in_valid_i  (in_valid3),
    .in_data_i   (in_data3),
    .in_ready_o  (in_ready3),
    .out_valid_o (out_valid3),
    .out_data_o  (out_data3),
    .out_ready_i (out_ready3),
    .count_o     (count3),
    .full_o      (full3),
    .empty_o     (empty3)
  );

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic ordy,
                               input logic fl, input logic rs);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int next_push;
    int next_pop;
    int cycles;

    flush3     = 1'b0;
    in_valid3  = 1'b0;
    in_data3   = '0;
    out_ready3 = 1'b0;

    // Reset both instances.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_count",     32'(count),     32'd0);
    checkOutput("rst_empty",     32'(empty),     32'd1);
    checkOutput("rst_full",      32'(full),      32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data",  out_data,       32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);

    // Fill the DEPTH=2 buffer with the consumer stalled.
    applyStimulus(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
    checkOutput("lat_pre_valid", 32'(out_valid), 32'd0);
    tick();
    applyStimulus(1'b1, 32'hA5A5_0002, 1'b0, 1'b0, 1'b0);
    checkOutput("push1_count", 32'(count), 32'd1);
    checkOutput("push1_data",  out_data,   32'hA5A5_0001);
    tick();

    // Full and stalled: this push must be refused.
    applyStimulus(1'b1, 32'h0000_0099, 1'b0, 1'b0, 1'b0);
    checkOutput("full_flag",     32'(full),     32'd1);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    checkOutput("full_count",    32'(count),    32'd2);
    checkOutput("full_data",     out_data,      32'hA5A5_0001);
    tick();

    // Full with consumer ready: push and pop together.
    applyStimulus(1'b1, 32'h0000_0003, 1'b1, 1'b0, 1'b0);
    checkOutput("stall_count",  32'(count),    32'd2);
    checkOutput("stall_data",   out_data,      32'hA5A5_0001);
    checkOutput("pp_in_ready",  32'(in_ready), 32'd1);
    tick();

    // Flush with a concurrent push while full and stalled.
    applyStimulus(1'b1, 32'h0000_0007, 1'b0, 1'b1, 1'b0);
    checkOutput("pp_count",        32'(count),    32'd2);
    checkOutput("pp_next_data",    out_data,      32'hA5A5_0002);
    checkOutput("flush_in_ready",  32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("flush_empty",     32'(empty),     32'd1);
    checkOutput("flush_count",     32'(count),     32'd0);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_out_data",  out_data,       32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("flush_no_emit", 32'(out_valid), 32'd0);

    // Reset in the middle of traffic.
    applyStimulus(1'b1, 32'h0000_0011, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h0000_0022, 1'b1, 1'b0, 1'b1);
    checkOutput("mid_count", 32'(count), 32'd1);
    checkOutput("mid_data",  out_data,   32'h0000_0011);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_rst_count",     32'(count),     32'd0);
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_out_data",  out_data,       32'd0);
    checkOutput("mid_rst_empty",     32'(empty),     32'd1);

    // Push into an empty buffer with a ready consumer.
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
`ifdef PIPE_BUF_BYPASS_EN
    checkOutput("byp_valid", 32'(out_valid), 32'd1);
    checkOutput("byp_data",  out_data,       32'hDEAD_BEEF);
    checkOutput("byp_count", 32'(count),     32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("byp_after_count", 32'(count), 32'd0);
    checkOutput("byp_after_empty", 32'(empty), 32'd1);
`else
    checkOutput("lat_same_valid", 32'(out_valid), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("lat_next_valid", 32'(out_valid), 32'd1);
    checkOutput("lat_next_data",  out_data,       32'hDEAD_BEEF);
    checkOutput("lat_next_count", 32'(count),     32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("lat_drain_empty", 32'(empty), 32'd1);
`endif

    // DEPTH=3: ten ordered pushes against a randomly stalling consumer.
    next_push = 0;
    next_pop  = 0;
    cycles    = 0;
    while (next_pop < 10 && cycles < 300) begin
      in_valid3  = (next_push < 10);
      in_data3   = 32'(next_push);
      out_ready3 = 1'($urandom_range(0, 1));
      #1;
      if (out_valid3 && out_ready3) begin
        checkOutput("d3_order", out_data3, 32'(next_pop));
        next_pop++;
      end
      if (in_valid3 && in_ready3) begin
        next_push++;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    in_valid3  = 1'b0;
    out_ready3 = 1'b0;
    #1;
    checkOutput("d3_all_popped", 32'(next_pop),   32'd10);
    checkOutput("d3_end_count",  32'(count3),     32'd0);
    checkOutput("d3_end_empty",  32'(empty3),     32'd1);
    checkOutput("d3_end_valid",  32'(out_valid3), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
